// File: rtl/btb_predictor.sv
// Branch target buffer with saturating-counter direction prediction for IF,
// trained from MEM at resolution time, plus debug performance counters.
module btb_predictor #(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pred_en,
    input  logic [ADDR_W-1:0] i_pred_pc,
    output logic              o_pred_hit,
    output logic              o_pred_taken,
    output logic [ADDR_W-1:0] o_pred_target,
    input  logic              i_upd_valid,
    input  logic [ADDR_W-1:0] i_upd_pc,
    input  logic              i_upd_is_branch,
    input  logic              i_upd_taken,
    input  logic [ADDR_W-1:0] i_upd_target,
    input  logic              i_upd_pred_taken,
    input  logic [ADDR_W-1:0] i_upd_pred_target,
    output logic              o_upd_mispredict,
    output logic [ADDR_W-1:0] o_upd_redirect_pc,
    input  logic              i_invalidate,
    output logic [31:0]       o_lookup_cnt,
    output logic [31:0]       o_hit_cnt,
    output logic [31:0]       o_mispred_cnt
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];
    logic [CNT_W-1:0]   r_cnt    [ENTRIES];
    logic [31:0]        r_lookup_cnt, r_hit_cnt, r_mispred_cnt;

    logic [IDX_W-1:0] w_pidx, w_uidx;
    logic [TAG_W-1:0] w_ptag, w_utag;
    logic             w_phit, w_uhit;

    // Lookup reads stored state only; a same-cycle update is not bypassed.
    assign w_pidx        = i_pred_pc[IDX_W+1:2];
    assign w_ptag        = i_pred_pc[ADDR_W-1:IDX_W+2];
    assign w_phit        = r_valid[w_pidx] && (r_tag[w_pidx] == w_ptag);
    assign o_pred_hit    = w_phit;
    assign o_pred_taken  = w_phit && r_cnt[w_pidx][CNT_W-1];
    assign o_pred_target = o_pred_taken ? r_target[w_pidx] : i_pred_pc + ADDR_W'(4);

    assign w_uidx = i_upd_pc[IDX_W+1:2];
    assign w_utag = i_upd_pc[ADDR_W-1:IDX_W+2];
    assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

    assign o_upd_mispredict = i_upd_valid && (i_upd_is_branch
        ? ((i_upd_taken != i_upd_pred_taken) ||
           (i_upd_taken && (i_upd_target != i_upd_pred_target)))
        : i_upd_pred_taken);
    assign o_upd_redirect_pc = (i_upd_is_branch && i_upd_taken) ? i_upd_target
                                                                 : i_upd_pc + ADDR_W'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= '0;
            end
        end else if (i_invalidate) begin
            // Flash clear drops any same-cycle update; counters/targets go stale.
            r_valid <= '0;
        end else if (i_upd_valid) begin
            if (i_upd_is_branch) begin
                if (w_uhit) begin
                    if (i_upd_taken) begin
                        if (r_cnt[w_uidx] != CNT_MAX) r_cnt[w_uidx] <= r_cnt[w_uidx] + CNT_W'(1);
                        r_target[w_uidx] <= i_upd_target;
                    end else if (r_cnt[w_uidx] != '0) begin
                        r_cnt[w_uidx] <= r_cnt[w_uidx] - CNT_W'(1);
                    end
                end else if (i_upd_taken) begin
                    r_valid[w_uidx]  <= 1'b1;
                    r_tag[w_uidx]    <= w_utag;
                    r_target[w_uidx] <= i_upd_target;
                    r_cnt[w_uidx]    <= CNT_WEAK;
                end
            end else if (w_uhit) begin
                // A non-branch hitting means an alias or stale entry: drop it.
                r_valid[w_uidx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lookup_cnt  <= '0;
            r_hit_cnt     <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (i_pred_en)              r_lookup_cnt  <= r_lookup_cnt + 32'd1;
            if (i_pred_en && w_phit)    r_hit_cnt     <= r_hit_cnt + 32'd1;
            if (o_upd_mispredict)       r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    assign o_lookup_cnt  = r_lookup_cnt;
    assign o_hit_cnt     = r_hit_cnt;
    assign o_mispred_cnt = r_mispred_cnt;
endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: driver pushes model expectations,
// a negedge monitor pops and compares whenever a lookup or update is presented.
module tb_btb_predictor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pred_en = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0, upd_is_branch = 1'b0, upd_taken = 1'b0, upd_pred_taken = 1'b0;
    logic [31:0] upd_pc = '0, upd_target = '0, upd_pred_target = '0;
    logic        upd_mispredict;
    logic [31:0] upd_redirect_pc;
    logic        invalidate = 1'b0;
    logic [31:0] lookup_cnt, hit_cnt, mispred_cnt;

    btb_predictor #(.ENTRIES(16), .ADDR_W(32), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_pred_en(pred_en), .i_pred_pc(pred_pc),
        .o_pred_hit(pred_hit), .o_pred_taken(pred_taken), .o_pred_target(pred_target),
        .i_upd_valid(upd_valid), .i_upd_pc(upd_pc), .i_upd_is_branch(upd_is_branch),
        .i_upd_taken(upd_taken), .i_upd_target(upd_target),
        .i_upd_pred_taken(upd_pred_taken), .i_upd_pred_target(upd_pred_target),
        .o_upd_mispredict(upd_mispredict), .o_upd_redirect_pc(upd_redirect_pc),
        .i_invalidate(invalidate),
        .o_lookup_cnt(lookup_cnt), .o_hit_cnt(hit_cnt), .o_mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          pe;
        bit          hit;
        bit          tk;
        logic [31:0] tgt;
        bit          uv;
        bit          mis;
        logic [31:0] rpc;
        logic [31:0] lk, hc, mc;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a table of (valid, tag, target, counter) per index.
    bit          m_v   [16];
    logic [31:0] m_tag [16];
    logic [31:0] m_tgt [16];
    int          m_cnt [16];
    logic [31:0] c_lk = 0, c_hc = 0, c_mc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 0;
        end
        c_lk = 0; c_hc = 0; c_mc = 0;
    endtask

    task automatic drive(input bit en, input logic [31:0] pc,
                         input bit uv, input logic [31:0] upc, input bit ub, input bit ut,
                         input logic [31:0] utgt, input bit upt, input logic [31:0] uptgt,
                         input bit inv);
        exp_t e;
        int pi, ui;
        bit uhit;
        @(posedge clk); #1;
        pred_en = en; pred_pc = pc;
        upd_valid = uv; upd_pc = upc; upd_is_branch = ub; upd_taken = ut;
        upd_target = utgt; upd_pred_taken = upt; upd_pred_target = uptgt;
        invalidate = inv;
        pi = int'((pc >> 2) % 16);
        e.pe  = en;
        e.hit = m_v[pi] && (m_tag[pi] == (pc >> 6));
        e.tk  = e.hit && (m_cnt[pi] >= 2);
        e.tgt = e.tk ? m_tgt[pi] : pc + 32'd4;
        e.uv  = uv;
        if (!uv)     e.mis = 0;
        else if (ub) e.mis = (ut != upt) || (ut && (utgt != uptgt));
        else         e.mis = upt;
        e.rpc = (ub && ut) ? utgt : upc + 32'd4;
        e.lk = c_lk; e.hc = c_hc; e.mc = c_mc;
        if (en || uv) q.push_back(e);
        if (en) c_lk++;
        if (en && e.hit) c_hc++;
        if (e.mis) c_mc++;
        ui   = int'((upc >> 2) % 16);
        uhit = m_v[ui] && (m_tag[ui] == (upc >> 6));
        if (inv) begin
            for (int i = 0; i < 16; i++) m_v[i] = 0;
        end else if (uv && ub && uhit) begin
            if (ut) begin
                m_cnt[ui] = (m_cnt[ui] < 3) ? m_cnt[ui] + 1 : 3;
                m_tgt[ui] = utgt;
            end else begin
                m_cnt[ui] = (m_cnt[ui] > 0) ? m_cnt[ui] - 1 : 0;
            end
        end else if (uv && ub && ut) begin
            m_v[ui] = 1; m_tag[ui] = upc >> 6; m_tgt[ui] = utgt; m_cnt[ui] = 2;
        end else if (uv && !ub && uhit) begin
            m_v[ui] = 0;
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic look(input logic [31:0] pc);
        drive(1, pc, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic upd(input logic [31:0] pc, input bit ub, input bit ut,
                       input logic [31:0] tgt, input bit upt);
        drive(0, 0, 1, pc, ub, ut, tgt, upt, tgt, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (pred_en || upd_valid)) begin
            if (q.size() == 0) begin
                chk("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                if (e.pe) begin
                    chk("pred_hit", {31'd0, pred_hit}, {31'd0, e.hit});
                    chk("pred_taken", {31'd0, pred_taken}, {31'd0, e.tk});
                    chk("pred_target", pred_target, e.tgt);
                end
                if (e.uv) begin
                    chk("upd_mispredict", {31'd0, upd_mispredict}, {31'd0, e.mis});
                    chk("upd_redirect_pc", upd_redirect_pc, e.rpc);
                end
                chk("lookup_cnt", lookup_cnt, e.lk);
                chk("hit_cnt", hit_cnt, e.hc);
                chk("mispred_cnt", mispred_cnt, e.mc);
            end
        end
    end

    function automatic logic [31:0] rnd_pc();
        if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFC;
        return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
    endfunction

    logic [31:0] lk0, hc0;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset state and first lookup.
        look(32'h40);
        // Cold taken branch: mispredict, allocate weakly taken.
        upd(32'h40, 1, 1, 32'h100, 0);
        look(32'h40);
        // Counter walk down, floor, saturate up, step back.
        upd(32'h40, 1, 0, 0, 1); upd(32'h40, 1, 0, 0, 1);
        look(32'h40);
        upd(32'h40, 1, 0, 0, 0);
        look(32'h40);
        repeat (4) upd(32'h40, 1, 1, 32'h100, 1);
        upd(32'h40, 1, 0, 0, 1);
        look(32'h40);
        // Alias at the same index with a different tag.
        look(32'h80);
        upd(32'h80, 1, 1, 32'h200, 0);
        look(32'h40); look(32'h80);
        upd(32'h80, 0, 0, 0, 0);
        look(32'h80);
        // Same-cycle update and lookup sees the old state; non-branch predicted taken.
        drive(1, 32'h40, 1, 32'h40, 1, 1, 32'h300, 0, 0, 0);
        look(32'h40);
        drive(0, 0, 1, 32'h7C, 0, 0, 0, 1, 32'h1234, 0);
        // Redirect wrap at the top of the address space.
        drive(1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
        // Invalidate beats a same-cycle taken update.
        drive(0, 0, 1, 32'h40, 1, 1, 32'h500, 0, 0, 1);
        look(32'h40); look(32'h80);

        // Ten lookups, three of which hit.
        upd(32'h40, 1, 1, 32'h600, 0);
        idle(); #2; lk0 = lookup_cnt; hc0 = hit_cnt;
        for (int i = 0; i < 10; i++) look((i % 3 == 0 && i < 9) ? 32'h40 : 32'h1000 + 32'(i * 4));
        idle(); #2;
        chk("lookup_delta", lookup_cnt - lk0, 32'd10);
        chk("hit_delta", hit_cnt - hc0, 32'd3);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] up, ut_t;
            bit ub, ut;
            up   = rnd_pc();
            ut_t = rnd_pc() & 32'hFFFF_FFFC;
            ub   = ($urandom_range(0, 4) != 0);
            ut   = ($urandom_range(0, 2) != 0);
            drive($urandom_range(0, 1) == 1, rnd_pc(),
                  $urandom_range(0, 3) != 0, up, ub, ut, ut_t,
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 1) == 1) ? ut_t : rnd_pc(),
                  $urandom_range(0, 49) == 0);
        end

        // Asynchronous reset mid-run: state clears with no clock edge.
        idle();
        #2 pred_pc = 32'h40;
        rst_n = 1'b0;
        #1;
        chk("rst_lookup_cnt", lookup_cnt, 32'd0);
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_mispred_cnt", mispred_cnt, 32'd0);
        chk("rst_pred_hit", {31'd0, pred_hit}, 32'd0);
        chk("rst_pred_target", pred_target, 32'h44);
        model_reset();
        #1 rst_n = 1'b1;

        for (int n = 0; n < 100; n++) begin
            drive($urandom_range(0, 1) == 1, rnd_pc(), $urandom_range(0, 1) == 1, rnd_pc(),
                  1, $urandom_range(0, 1) == 1, rnd_pc() & 32'hFFFF_FFFC, 0, 0, 0);
        end
        idle(); idle();
        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Parametrised branch target buffer with saturating-counter direction prediction for the IF stage of the 5-stage MIPS pipeline.
- The current pipeline resolves every jump/branch in MEM and always fetches sequentially until then. This block gives IF a same-cycle predicted next PC.
- It is updated from MEM at resolution time and computes the mispredict/redirect signal used to flush the front end.
- It also keeps performance counters for debug readout.

Parameters:
- ENTRIES, 16: number of BTB entries; power of 2, at least 2. IDX_W = log2(ENTRIES).
- ADDR_W, 32: PC/target width. Tag = pc[ADDR_W-1 : IDX_W+2]; index = pc[IDX_W+1:2]; pc[1:0] is ignored.
- CNT_W, 2: saturating counter width, at least 1. Predict taken when the counter MSB = 1.

Ports:
- clk  in  1  main clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- pred_en  in  1  IF lookup valid (advances the lookup counter)
- pred_pc  in  ADDR_W  IF fetch address
- pred_hit  out  1  valid entry with matching tag
- pred_taken  out  1  hit and counter MSB = 1
- pred_target  out  ADDR_W  stored target if pred_taken, else pred_pc+4
- upd_valid  in  1  MEM-stage instruction valid for update
- upd_pc  in  ADDR_W  PC of the MEM-stage instruction
- upd_is_branch  in  1  instruction is a jump/branch
- upd_taken  in  1  resolved direction (1 for unconditional jumps)
- upd_target  in  ADDR_W  resolved target
- upd_pred_taken  in  1  pred_taken carried down the pipeline with this instruction
- upd_pred_target  in  ADDR_W  pred_target carried down the pipeline with this instruction
- upd_mispredict  out  1  front-end flush request
- upd_redirect_pc  out  ADDR_W  correct next PC
- invalidate  in  1  clear all valid bits
- lookup_cnt, hit_cnt, mispred_cnt  out  32 each  performance counters

Behaviour:
- Storage per entry: valid, tag, target[ADDR_W], counter[CNT_W].
- Lookup path is purely combinational from the stored state; there is no bypass of a same-cycle update.
- upd_mispredict = upd_valid & (upd_is_branch ? (upd_taken != upd_pred_taken) | (upd_taken & upd_target != upd_pred_target) : upd_pred_taken). Combinational.
- upd_redirect_pc = (upd_is_branch & upd_taken) ? upd_target : upd_pc+4. ADDR_W arithmetic, wraps modulo 2^ADDR_W. Combinational.
- Update is written at the clock edge when upd_valid = 1. Let u_hit = the entry at upd_pc's index is valid and its tag matches.
  - branch, hit, taken: counter = min(counter+1, 2^CNT_W-1); target = upd_target.
  - branch, hit, not taken: counter = max(counter-1, 0); target unchanged.
  - branch, miss, taken: allocate (overwrite the indexed entry). valid = 1, new tag, target = upd_target, counter = 2^(CNT_W-1) (weakly taken).
  - branch, miss, not taken: no change.
  - non-branch, hit (alias/stale entry): valid = 0.
  - non-branch, miss: no change.
- invalidate: all valid = 0 at the next edge. It takes priority over a same-cycle update; counters and targets are retained but unused.
- Perf counters, 32-bit, wrap to 0:
  - lookup_cnt increments on pred_en.
  - hit_cnt increments on pred_en & pred_hit.
  - mispred_cnt increments on upd_mispredict.
- Reset (rst_n = 0, asynchronous, mid-operation allowed):
  - All valid = 0, all counters = 0, all targets = 0, all tags = 0.
  - All perf counters = 0.
  - As a result, pred_hit = 0, pred_taken = 0 and pred_target = pred_pc+4 immediately.
  - Combinational update outputs follow their inputs regardless of reset.
- Latency: lookup 0 cycles; update is visible to lookups 1 cycle after the edge.

Test Plan (ENTRIES=16, ADDR_W=32, CNT_W=2):
1. Reset, then lookup pred_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44. Pulse rst_n low mid-run -> all perf counters read 0 with no clock edge.
2. Update upd_pc=0x40, branch, taken, upd_target=0x100, upd_pred_taken=0 -> upd_mispredict=1, upd_redirect_pc=0x100, mispred_cnt=1. Next cycle, lookup 0x40 -> hit=1, taken=1, target=0x100.
3. From (2), apply two not-taken updates at 0x40 -> counter 2→1→0; lookup taken=0, target=0x44; a third not-taken leaves it at 0. Then four taken updates -> counter saturates at 3; a single not-taken -> 2, still predicts taken.
4. Alias: entry at 0x40 valid. Lookup 0x80 (same index 0, different tag) -> hit=0. Taken update 0x80→0x200 replaces the entry, after which 0x40 misses. A non-branch update at 0x80 -> entry invalidated.
5. Update and lookup at the same pc in the same cycle -> lookup reflects the pre-update state. A non-branch update with upd_pred_taken=1, upd_pc=0x7C -> upd_mispredict=1, upd_redirect_pc=0x80.
6. invalidate together with a taken update at 0x40 -> next cycle all lookups miss, including 0x40. Check hit_cnt and lookup_cnt counts across 10 pred_en cycles with 3 hits -> 10 and 3.
